// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//
// N-channel registered stream multiplexer with valid/ready handshakes.
// An internal arbiter picks one valid input channel per cycle, either
// round-robin (starting at a rotating pointer) or fixed priority (lowest
// index wins). The winner is captured into a single output register stage.
// That stage sustains one beat per cycle while the consumer keeps
// out_ready high.
//
// Parameters:
//   N_CH     - number of input channels (>= 1, any value)
//   WIDTH    - data bits per channel
//   ARB_MODE - 0 = round-robin, 1 = fixed priority (lowest index)
//   CH_W     - channel index width, derived from N_CH (do not override)
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous, active-high reset
//   in_data   - packed input data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  - per-channel valid
//   in_ready  - per-channel ready (combinational, one-hot or zero)
//   out_data  - registered selected data
//   out_ch    - registered index of the channel that supplied out_data
//   out_valid - registered output valid
//   out_ready - consumer ready

module stream_mux_rr #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int ARB_MODE = 0,
    parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [CH_W-1:0]  ptr;
    logic [CH_W-1:0]  grant;
    logic [WIDTH-1:0] grant_data;
    logic             any_valid;
    logic             load;
    logic             found;
    logic [CH_W-1:0]  ptr_next;

    assign any_valid = |in_valid;
    assign load      = !out_valid || out_ready;

    // Search N_CH candidates starting at the base index and wrapping
    // modulo N_CH. The base is ptr in round-robin mode and 0 in
    // fixed-priority mode. The first valid candidate wins.
    always_comb begin
        int unsigned idx;
        grant      = '0;
        grant_data = '0;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (ARB_MODE == 0) begin
                idx = 32'(ptr) + k;
            end else begin
                idx = k;
            end
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && in_valid[idx]) begin
                found      = 1'b1;
                grant      = CH_W'(idx);
                grant_data = in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Only the granted channel sees ready. Ready is also held low while
    // reset is asserted, because out_valid alone would otherwise report
    // load=1 during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && load && any_valid) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (ARB_MODE == 0) begin
            if (grant == CH_W'(N_CH - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant;
                ptr       <= ptr_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr.
// Two instances (round-robin and fixed-priority) share the same stimulus.
// Both are checked every cycle against a cycle-level reference model.
// Directed sequences for reset, fairness, wrap/skip, backpressure, fixed
// priority and async reset are followed by randomized traffic.

module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           out_ready;
    logic [N-1:0]   rdy_rr, rdy_fp;
    logic [W-1:0]   od_rr, od_fp;
    logic [1:0]     oc_rr, oc_fp;
    logic           ov_rr, ov_fp;

    int checks   = 0;
    int failures = 0;

    // Reference model state: index 0 = round-robin, 1 = fixed priority.
    int m_ptr;
    int m_ch   [2];
    int m_data [2];
    bit m_valid[2];

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(N), .WIDTH(W), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_rr), .out_data(od_rr), .out_ch(oc_rr),
        .out_valid(ov_rr), .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(N), .WIDTH(W), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_fp), .out_data(od_fp), .out_ch(oc_fp),
        .out_valid(ov_fp), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First valid channel at or after 'start', wrapping modulo N; -1 if none.
    function automatic int pick(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        bit ld;
        int g;
        ld = !m_valid[m] || out_ready;
        g  = pick((m == 0) ? m_ptr : 0, in_valid);
        if (rst || !ld || g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int m = 0; m < 2; m++) begin
            m_ch[m] = 0; m_data[m] = 0; m_valid[m] = 0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int g;
            g = pick((m == 0) ? m_ptr : 0, in_valid);
            if (!m_valid[m] || out_ready) begin
                if (g >= 0) begin
                    m_valid[m] = 1;
                    m_ch[m]    = g;
                    m_data[m]  = (in_data >> (W * g)) & 'hFF;
                    if (m == 0) m_ptr = (g + 1) % N;
                end else begin
                    m_valid[m] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("rr_ready", 32'(rdy_rr), 32'(exp_ready(0)));
        check("rr_valid", 32'(ov_rr),  32'(m_valid[0]));
        check("rr_data",  32'(od_rr),  m_data[0]);
        check("rr_ch",    32'(oc_rr),  m_ch[0]);
        check("fp_ready", 32'(rdy_fp), 32'(exp_ready(1)));
        check("fp_valid", 32'(ov_fp),  32'(m_valid[1]));
        check("fp_data",  32'(od_fp),  m_data[1]);
        check("fp_ch",    32'(oc_fp),  m_ch[1]);
    endtask

    // One cycle: drive inputs, compare at negedge, advance model at posedge.
    task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    localparam logic [N*W-1:0] DSEQ = 32'hA3A2A1A0;

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = DSEQ;
        out_ready = 1'b1;
        model_reset();

        // Reset held with all inputs valid.
        @(negedge clk);
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        #1 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check("rst_release_valid", 32'(ov_rr), 1);
        check("rst_release_ch",    32'(oc_rr), 0);

        // Round-robin fairness: channels 1,2,3,0,... after the first load of 0.
        for (int k = 0; k < 8; k++) begin
            cyc(4'hF, DSEQ, 1'b1);
            check("fair_ch",   32'(oc_rr), (k + 1) % 4);
            check("fair_data", 32'(od_rr), 32'hA0 + (k + 1) % 4);
            check("fp_all_ch", 32'(oc_fp), 0);
        end

        // Wrap and skip: grant channel 2 (pointer moves to 3), then 0101 -> 0, 2, 0.
        cyc(4'b0100, DSEQ, 1'b1);
        check("skip_ch2", 32'(oc_rr), 2);
        cyc(4'b0101, DSEQ, 1'b1);
        check("wrap_ch0", 32'(oc_rr), 0);
        cyc(4'b0101, DSEQ, 1'b1);
        check("wrap_ch2", 32'(oc_rr), 2);
        cyc(4'b0101, DSEQ, 1'b1);
        check("wrap_ch0b", 32'(oc_rr), 0);

        // Backpressure: load channel 1 with 5C, then stall five cycles.
        cyc(4'b0010, 32'hA3A25CA0, 1'b1);
        check("bp_load_ch", 32'(oc_rr), 1);
        for (int k = 0; k < 5; k++) begin
            cyc(4'hF, DSEQ, 1'b0);
            check("bp_hold_data",  32'(od_rr),  32'h5C);
            check("bp_hold_ch",    32'(oc_rr),  1);
            check("bp_hold_ready", 32'(rdy_rr), 0);
        end
        cyc(4'hF, DSEQ, 1'b1);
        check("bp_resume_valid", 32'(ov_rr), 1);
        check("bp_resume_ch",    32'(oc_rr), 2);
        check("bp_resume_data",  32'(od_rr), 32'hA2);

        // Fixed priority.
        for (int k = 0; k < 3; k++) begin
            cyc(4'b1110, DSEQ, 1'b1);
            check("fp_prio_ch1", 32'(oc_fp), 1);
        end
        cyc(4'b1100, DSEQ, 1'b1);
        check("fp_prio_ch2", 32'(oc_fp), 2);

        // Async reset mid-stall.
        cyc(4'hF, DSEQ, 1'b1);
        cyc(4'hF, DSEQ, 1'b0);
        check("stall_valid", 32'(ov_rr), 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_rr_valid", 32'(ov_rr),  0);
        check("arst_fp_valid", 32'(ov_fp),  0);
        check("arst_rr_ready", 32'(rdy_rr), 0);
        check("arst_rr_ch",    32'(oc_rr),  0);
        out_ready = 1'b1;
        @(negedge clk);
        compare_all();
        #1 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check("arst_restart_ch", 32'(oc_rr), 0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(4'($urandom_range(0, 15)), 32'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel registered stream multiplexer with valid/ready handshakes and selectable arbitration. It generalises the team's 2:1 select mux to N_CH channels of WIDTH bits. The select input is replaced by an internal arbiter: round-robin or fixed-priority. A single output register stage supports full throughput with backpressure. It sits between multiple producer streams and one shared consumer, such as a shared bus or serialiser.

## Interface
Parameters:
- N_CH, 4, number of input channels (≥1; non-power-of-2 legal)
- WIDTH, 8, data bits per channel
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- CH_W, max(1, clog2(N_CH)), width of channel index (derived, not overridden)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready (combinational, one-hot or zero)
- out_data  output  WIDTH  registered selected data
- out_ch  output  CH_W  registered index of channel that supplied out_data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready

## Operation
- load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Grant g, evaluated combinationally each cycle over in_valid:
  - ARB_MODE=0: first valid channel searching upward from ptr, wrapping N_CH-1 → 0.
  - ARB_MODE=1: lowest-index valid channel. ptr is unused and stays 0.
- in_ready[g] = load && any(in_valid). All other in_ready bits are 0. in_ready = 0 when load=0 or no channel is valid.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - ptr <= (g == N_CH-1) ? 0 : g+1 (round-robin only)
- load=1 with no valid input: out_valid <= 0. out_data and out_ch hold their last values.
- load=0: out_data, out_ch, out_valid and ptr all hold.
- ptr advances only on a transfer, never on an idle cycle.
- in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- N_CH=1: the block degenerates to a one-stage valid/ready register slice with out_ch=0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_ch=0, ptr=0.
  - in_ready=0 while rst=1.
- Reset asserted mid-transfer: any held beat is discarded and not replayed. The first beat after reset release is arbitrated from ptr=0.
- Latency: input transfer at edge k → out_valid=1 with that beat from edge k until the consumer accepts it.
- Throughput: one beat per cycle while out_ready=1 continuously.
- Stall: while out_valid && !out_ready, out_data and out_ch are stable and in_ready=0.
- Simultaneous consume and load: if out_valid && out_ready and an input is valid in the same cycle, the new beat replaces the old with no bubble.
- Fairness: in round-robin mode, with all channels continuously valid and out_ready=1, every channel is granted exactly once per N_CH consecutive transfers.

## Test plan
- Reset: hold rst=1 with in_valid=4'b1111 → out_valid=0, out_data=0, out_ch=0, in_ready=0. Release; the next edge loads channel 0.
- RR fairness (N_CH=4, WIDTH=8, ARB_MODE=0): in_valid=1111, channel i data=8'hA0+i, out_ready=1 → out_ch sequence 0,1,2,3,0,… and out_data A0,A1,A2,A3,A0. One in_ready bit high per cycle.
- Wrap and skip: ptr=3, in_valid=0101 → grant 0, then 2, then 0. ptr never rests on an invalid channel after a grant.
- Backpressure: load channel 1 (data 8'h5C), drive out_ready=0 for 5 cycles with all inputs valid → out_data=5C and out_ch=1 stable, in_ready=0000. Raise out_ready → next beat loads the same cycle with no bubble.
- Fixed priority (ARB_MODE=1): in_valid=1110 continuous → out_ch=1 every beat. Drop in_valid[1] → out_ch=2.
- Async reset mid-stall: out_valid=1 held under out_ready=0, assert rst between edges → out_valid drops to 0 immediately. After release, arbitration restarts at channel 0.
